text_layer_gen: RTL
===================

Name: text_layer_gen

Overview:
- Parametrised character-cell text layer, the successor to the fixed single-row character demo.
- Sits between vga_core (timing) and the RGB output pins in ogege.
- Holds a writable text buffer (char code plus fg/bg palette index per cell), a 16-entry palette, a blinking cursor and a border colour.
- Emits pixel colour and delayed syncs aligned to a fixed pipeline latency.

Parameters:
HSZ, 10, width of hcount_i
VSZ, 9, width of vcount_i
CHAR_W, 8, cell width in pixels; must be a power of 2
CHAR_H, 12, cell height in pixels; any value 1..16
COLS, 80, text columns; COLS*CHAR_W <= active width
ROWS, 40, text rows
COLOR_W, 12, RGB colour width, split equally across R/G/B
BLINK_FRAMES, 30, frames per cursor blink phase
AW, $clog2(COLS*ROWS), text buffer address width

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous active-high reset
hcount_i  in  HSZ  horizontal pixel count from vga_core
vcount_i  in  VSZ  vertical line count from vga_core
de_i  in  1  active video from vga_core
hsync_i  in  1  hsync from vga_core
vsync_i  in  1  vsync from vga_core
wr_en_i  in  1  text buffer write strobe
wr_addr_i  in  AW  cell index = row*COLS+col
wr_data_i  in  16  [7:0] char, [11:8] fg index, [15:12] bg index
pal_we_i  in  1  palette write strobe
pal_idx_i  in  4  palette entry
pal_data_i  in  COLOR_W  palette colour
border_i  in  COLOR_W  colour for active pixels outside the text area
cursor_en_i  in  1  cursor enable
cursor_addr_i  in  AW  cursor cell index
rgb_o  out  COLOR_W  pixel colour
hsync_o  out  1  hsync delayed to match rgb_o
vsync_o  out  1  vsync delayed to match rgb_o
de_o  out  1  de delayed to match rgb_o

Behaviour:
- Reset:
  - rgb_o, de_o, hsync_o, vsync_o = 0; all pipeline valid bits cleared.
  - Cell/line counters and blink counter = 0; blink phase = 0.
  - Palette: entry 1 = 12'h008, entry 15 = 12'hFFF, all others = 0.
  - Text buffer is not reset.
- Latency: exactly 3 clocks from hcount_i/vcount_i/de_i/syncs to rgb_o/de_o/syncs_o. Syncs and de go through an identical 3-stage delay.
- Line tracking, updated on clk when hcount_i==0:
  - If vcount_i==0: sub_row=0, cell_row=0, row_base=0.
  - Otherwise sub_row++. When sub_row==CHAR_H-1 it wraps to 0, cell_row++ and row_base+=COLS.
- Stage 1:
  - col = hcount_i>>log2(CHAR_W).
  - in_text = de_i && col<COLS && cell_row<ROWS.
  - Text buffer read address = row_base+col. Latch in_text, column bits (hcount_i[log2(CHAR_W)-1:0]) and sub_row.
- Stage 2:
  - Buffer word is valid.
  - Font row = font_rom(char, sub_row).
  - fg/bg colours are read from the palette.
  - is_cursor = cursor_en_i && blink_phase && (addr == cursor_addr_i).
- Stage 3:
  - Pixel bit = font_row[CHAR_W-1-colbit]; MSB is leftmost.
  - rgb_o = bit ? fg : bg, with fg/bg swapped when is_cursor.
  - rgb_o = border_i if de && !in_text; rgb_o = 0 if !de.
- Text buffer:
  - Single write port, read-first. A write and read of the same address in one clock returns the old word; the new word is visible the next clock.
  - Writes with wr_addr_i >= COLS*ROWS are ignored.
- Palette: written on pal_we_i. A write takes effect for stage-2 reads on the following clock.
- Blink:
  - frame_cnt increments when hcount_i==0 && vcount_i==0.
  - At frame_cnt==BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - cursor_en_i==0 forces no inversion but does not stop the counter.
- Reset mid-frame: outputs return to 0 the next clock. Line counters resync at the next vcount_i==0 line; rows before that resync render with row 0 addressing.
- Width rules: row_base and addresses are AW bits. Palette indices are 4 bits. rgb_o is split as R=[COLOR_W-1 -: COLOR_W/3], G and B following.

Decomposition:
- Package ogege_pkg: cell word field positions (CHAR_LSB/MSB, FG_LSB, BG_LSB), default palette constants, PIPE_LAT=3.
- One sub-module, font_rom_8x12: combinational (char, sub_row) -> CHAR_W-bit font row. Glyph table shared with the existing character blender.
- Text RAM and palette are inferred inside text_layer_gen.

Test Plan:
- Write cell 0 = 16'hF141 ('A', fg 1, bg 15), drive frame from reset -> pixel (0,0) rgb_o appears exactly 3 clocks after hcount_i=0,vcount_i=0. Colours match the font bits: set bits 12'h008, clear bits 12'hFFF.
- Write cell COLS (row 1, col 0) = 16'h0F20 with CHAR_H=12 -> line 12 pixels 0..7 fetch address 80. Line 11 still fetches address 0.
- border_i=12'hF00, hcount_i=COLS*CHAR_W=640 with de_i=1 (ext timing) -> rgb_o=12'hF00. With de_i=0 -> rgb_o=0, de_o=0 after 3 clocks.
- pal_we_i idx 15 = 12'h0F0 mid-line -> next fetched cell using fg 15 renders 12'h0F0. Write to wr_addr_i=COLS*ROWS leaves cell 0 unchanged.
- cursor_en_i=1, cursor_addr_i=5, BLINK_FRAMES=2 -> cell 5 fg/bg swapped on frames 2-3, normal on frames 0-1 and 4-5.
- Assert rst_i for 1 clock mid-line -> rgb_o, syncs_o, de_o = 0 next clock. Correct rendering resumes from the next vcount_i=0 line.

Source files
------------

// File: rtl/ogege_pkg.sv
// Shared constants for the ogege text layer: cell word layout, default palette
// entries, pipeline depth and the sync/de bundle carried down the pipe.
package ogege_pkg;
    localparam int CHAR_LSB = 0;
    localparam int CHAR_MSB = 7;
    localparam int FG_LSB   = 8;
    localparam int BG_LSB   = 12;
    localparam int PIPE_LAT = 3;

    localparam logic [11:0] PAL_DEF_1  = 12'h008;
    localparam logic [11:0] PAL_DEF_15 = 12'hFFF;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;
endpackage

// File: rtl/font_rom_8x12.sv
// Combinational 8x12 glyph table; the glyph row is left-aligned into CHAR_W bits
// so that bit CHAR_W-1 is always the leftmost pixel.
module font_rom_8x12 #(
    parameter int CHAR_W = 8
) (
    input  logic [7:0]        char_i,
    input  logic [3:0]        sub_row_i,
    output logic [CHAR_W-1:0] row_o
);
    localparam int NB = (CHAR_W < 8) ? CHAR_W : 8;

    logic [7:0] glyph;

    always_comb begin
        glyph = 8'h00;
        case (char_i)
            8'h00, 8'h20: glyph = 8'h00;
            8'h41: begin
                case (sub_row_i)
                    4'd1:                   glyph = 8'h18;
                    4'd2:                   glyph = 8'h3C;
                    4'd3, 4'd4:             glyph = 8'h66;
                    4'd5:                   glyph = 8'h7E;
                    4'd6, 4'd7, 4'd8:       glyph = 8'h66;
                    default:                glyph = 8'h00;
                endcase
            end
            // Undefined codes draw a hollow box so missing glyphs stay visible.
            default: begin
                if (sub_row_i == 4'd0 || sub_row_i == 4'd11) glyph = 8'hFF;
                else if (sub_row_i < 4'd11)                  glyph = 8'h81;
                else                                         glyph = 8'h00;
            end
        endcase
    end

    always_comb begin
        row_o = '0;
        for (int i = 0; i < NB; i++) row_o[CHAR_W-1-i] = glyph[7-i];
    end
endmodule

// File: rtl/text_layer_gen.sv
// Character-cell text layer: text RAM + palette + blinking cursor + border,
// rendered through a fixed 3-clock pipeline with matching sync/de delay.
module text_layer_gen
    import ogege_pkg::*;
#(
    parameter int HSZ          = 10,
    parameter int VSZ          = 9,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 12,
    parameter int COLS         = 80,
    parameter int ROWS         = 40,
    parameter int COLOR_W      = 12,
    parameter int BLINK_FRAMES = 30,
    parameter int AW           = $clog2(COLS*ROWS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [HSZ-1:0]     hcount_i,
    input  logic [VSZ-1:0]     vcount_i,
    input  logic               de_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_addr_i,
    input  logic [15:0]        wr_data_i,
    input  logic               pal_we_i,
    input  logic [3:0]         pal_idx_i,
    input  logic [COLOR_W-1:0] pal_data_i,
    input  logic [COLOR_W-1:0] border_i,
    input  logic               cursor_en_i,
    input  logic [AW-1:0]      cursor_addr_i,
    output logic [COLOR_W-1:0] rgb_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o
);
    localparam int NCELLS = COLS * ROWS;
    localparam int CB     = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
    localparam int FCW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [3:0]         sub_row_q, sub_row_d;
    logic [VSZ-1:0]     cell_row_q, cell_row_d;
    logic [AW-1:0]      row_base_q, row_base_d;
    logic [FCW-1:0]     frame_cnt_q, frame_cnt_d;
    logic               blink_q, blink_d;

    logic [15:0]        mem_q [NCELLS];
    logic [15:0]        rd_q;
    logic [COLOR_W-1:0] pal_q [16];

    logic               s1_in_text_q, s2_in_text_q;
    logic [CB-1:0]      s1_colbit_q, s2_colbit_q;
    logic [3:0]         s1_sub_row_q;
    logic [AW-1:0]      s1_addr_q;
    logic [CHAR_W-1:0]  s2_font_q;
    logic [COLOR_W-1:0] s2_fg_q, s2_bg_q;
    logic               s2_cur_q;
    logic [COLOR_W-1:0] rgb_q, rgb_d;
    sync_t              sync_pipe_q [PIPE_LAT];

    logic [HSZ-1:0]     col;
    logic               in_text;
    logic [AW-1:0]      rd_addr;
    logic               frame_tick;
    logic [CHAR_W-1:0]  font_row;
    logic               pix;

    // Next line state is used by stage 1 directly, so pixel 0 of a line
    // already addresses the row it belongs to.
    always_comb begin
        sub_row_d  = sub_row_q;
        cell_row_d = cell_row_q;
        row_base_d = row_base_q;
        if (hcount_i == '0) begin
            if (vcount_i == '0) begin
                sub_row_d  = '0;
                cell_row_d = '0;
                row_base_d = '0;
            end else if (sub_row_q == 4'(CHAR_H-1)) begin
                sub_row_d  = '0;
                cell_row_d = cell_row_q + 1'b1;
                row_base_d = row_base_q + AW'(COLS);
            end else begin
                sub_row_d  = sub_row_q + 1'b1;
            end
        end
    end

    always_comb begin
        frame_tick  = (hcount_i == '0) && (vcount_i == '0);
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_tick) begin
            if (frame_cnt_q == FCW'(BLINK_FRAMES-1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        col     = hcount_i >> CB;
        in_text = de_i && (int'(col) < COLS) && (int'(cell_row_d) < ROWS);
        rd_addr = row_base_d + AW'(col);
    end

    // Read-first: a same-address write is only seen by the next read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && int'(wr_addr_i) < NCELLS) mem_q[wr_addr_i] <= wr_data_i;
        rd_q <= mem_q[rd_addr];
    end

    font_rom_8x12 #(.CHAR_W(CHAR_W)) u_font (
        .char_i    (rd_q[CHAR_MSB:CHAR_LSB]),
        .sub_row_i (s1_sub_row_q),
        .row_o     (font_row)
    );

    always_ff @(posedge clk_i) begin
        s1_colbit_q  <= hcount_i[CB-1:0];
        s1_sub_row_q <= sub_row_d;
        s1_addr_q    <= rd_addr;
        s2_colbit_q  <= s1_colbit_q;
        s2_font_q    <= font_row;
        s2_fg_q      <= pal_q[rd_q[FG_LSB +: 4]];
        s2_bg_q      <= pal_q[rd_q[BG_LSB +: 4]];
        s2_cur_q     <= cursor_en_i && blink_q && (s1_addr_q == cursor_addr_i);
    end

    always_comb begin
        pix   = s2_font_q[CB'(CHAR_W-1) - s2_colbit_q];
        rgb_d = '0;
        if (sync_pipe_q[PIPE_LAT-2].de) begin
            if (!s2_in_text_q) rgb_d = border_i;
            else               rgb_d = (pix ^ s2_cur_q) ? s2_fg_q : s2_bg_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sub_row_q    <= '0;
            cell_row_q   <= '0;
            row_base_q   <= '0;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            s1_in_text_q <= 1'b0;
            s2_in_text_q <= 1'b0;
            rgb_q        <= '0;
            for (int i = 0; i < PIPE_LAT; i++) sync_pipe_q[i] <= '0;
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= (i == 1)  ? COLOR_W'(PAL_DEF_1)  :
                            (i == 15) ? COLOR_W'(PAL_DEF_15) : COLOR_W'(0);
            end
        end else begin
            sub_row_q    <= sub_row_d;
            cell_row_q   <= cell_row_d;
            row_base_q   <= row_base_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            s1_in_text_q <= in_text;
            s2_in_text_q <= s1_in_text_q;
            rgb_q        <= rgb_d;
            sync_pipe_q[0] <= '{de: de_i, hs: hsync_i, vs: vsync_i};
            for (int i = 1; i < PIPE_LAT; i++) sync_pipe_q[i] <= sync_pipe_q[i-1];
            if (pal_we_i) pal_q[pal_idx_i] <= pal_data_i;
        end
    end

    assign rgb_o   = rgb_q;
    assign de_o    = sync_pipe_q[PIPE_LAT-1].de;
    assign hsync_o = sync_pipe_q[PIPE_LAT-1].hs;
    assign vsync_o = sync_pipe_q[PIPE_LAT-1].vs;
endmodule
